// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and FSM encoding for the spi_slave SPI endpoint.
package spi_pkg;

  localparam int WORD_W_DEF = 32;

  // Counter must hold 0..WORD_W+1 so over-long frames stay distinguishable.
  function automatic int cnt_width(input int word_w);
    return $clog2(word_w + 2);
  endfunction

  localparam int CNT_W = cnt_width(WORD_W_DEF);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the tx/rx word handshake between a master-side
// agent and the spi_slave endpoint.
interface spi_slave_if #(
  parameter int WORD_W = 32
);

  logic              sck;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  sck, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output sck, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, frame_err, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous input with
// single-cycle rise/fall pulses taken against one extra registered copy.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   lvl;

  // Chain resets low: an input already high leaves reset as a clean rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 peripheral endpoint, one WORD_W-bit word per cs-low frame.
// Build option SPI_SLAVE_ECHO_EN: on tx underrun, echo the last received word instead of zero.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  localparam int            CW       = cnt_width(WORD_W);
  localparam logic [CW-1:0] CNT_WORD = CW'(WORD_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WORD_W + 1);

  state_t state, state_nxt;

  logic                   sck_rise, sck_fall;
  logic                   cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  logic [CW-1:0]          cnt, cnt_nxt;
  logic [WORD_W-2:0]      rx_sh;
  logic [WORD_W-1:0]      rx_word;
  logic [WORD_W-1:0]      rx_data;
  logic [WORD_W-1:0]      tx_sh;
  logic [WORD_W-1:0]      buf_data;
  logic [WORD_W-1:0]      underrun_word;
  logic                   buf_full;
  logic                   rx_valid, frame_err;
  logic                   busy, miso;
  logic                   shift_in, shift_out, consume, accept, word_done;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_SAT) ? c : c + CW'(1);
  endfunction

  // Input conditioning
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk (clk),
    .rst (rst),
    .din (bus.sck),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .din (bus.cs),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  always_ff @(posedge clk) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; the cs chain resets low, so "cs high" appears as cs_rise
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_IDLE: if (cs_rise) state_nxt = IDLE;
      IDLE:      if (cs_fall) state_nxt = SHIFT;
      SHIFT:     if (cs_rise) state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == SHIFT);
    miso = busy && tx_sh[WORD_W-1];
  end

  // Frame-level events; cnt_nxt already includes a same-cycle sck_rise
  always_comb begin
    shift_in  = (state == SHIFT) && sck_rise;
    shift_out = (state == SHIFT) && sck_fall && (cnt != '0);
    consume   = (state == IDLE) && cs_fall;
    accept    = bus.tx_valid && !buf_full;
    cnt_nxt   = shift_in ? sat_inc(cnt) : cnt;
    rx_word   = {rx_sh, mosi_s};
    word_done = shift_in && (cnt == CNT_LAST);
  end

`ifdef SPI_SLAVE_ECHO_EN
  assign underrun_word = rx_data;
`else
  assign underrun_word = '0;
`endif

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      buf_full  <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
    end else begin
      if (consume)       cnt <= '0;
      else if (shift_in) cnt <= cnt_nxt;

      // A new word accepted in the consume cycle stays buffered.
      if (accept)       buf_full <= 1'b1;
      else if (consume) buf_full <= 1'b0;

      rx_valid  <= word_done;
      frame_err <= (state == SHIFT) && cs_rise && (cnt_nxt != CNT_WORD);
      if (word_done) rx_data <= rx_word;
    end
  end

  // Data path
  always_ff @(posedge clk) begin
    if (accept)   buf_data <= bus.tx_data;
    if (shift_in) rx_sh    <= rx_word[WORD_W-2:0];
    if (consume)        tx_sh <= buf_full ? buf_data : underrun_word;
    else if (shift_out) tx_sh <= {tx_sh[WORD_W-2:0], 1'b0};
  end

  assign bus.miso      = miso;
  assign bus.tx_ready  = !buf_full;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives spi_slave as a mode-0 SPI master and checks it against a
// word-level model of the buffer, echo and frame rules.
module tb_spi_slave;

  localparam int W    = 32;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  spi_slave_if #(.WORD_W(W)) bus ();

  spi_slave #(.WORD_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rxv_seen  = 0;
  int ferr_seen = 0;

  logic [W-1:0] m_rx_data;
  logic         m_buf_full;
  logic [W-1:0] m_buf;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1)  rxv_seen++;
    if (bus.frame_err === 1'b1) ferr_seen++;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] underrun_word();
`ifdef SPI_SLAVE_ECHO_EN
    return m_rx_data;
`else
    return '0;
`endif
  endfunction

  task automatic push(input logic [W-1:0] w);
    @(negedge clk);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    if (!m_buf_full) begin
      m_buf_full = 1'b1;
      m_buf      = w;
    end
    check("tx_ready_after_push", W'(bus.tx_ready), '0);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input int nbits, input int rst_at,
                            input bit inject, input logic [W-1:0] inj_word, input string tag);
    logic [W-1:0] got;
    logic [W-1:0] exp_tx;
    logic [W-1:0] extra;
    logic [W-1:0] mask;
    int           rxv0;
    int           ferr0;
    int           n_eff;
    bit           was_reset;
    was_reset = 1'b0;
    rxv0      = rxv_seen;
    ferr0     = ferr_seen;
    exp_tx    = m_buf_full ? m_buf : underrun_word();
    m_buf_full = 1'b0;
    got       = '0;
    extra     = $urandom;

    @(negedge clk);
    bus.cs = 1'b0;
    for (int k = 0; k < HALF; k++) begin
      @(negedge clk);
      if (inject && k == 1) begin
        bus.tx_data  = inj_word;
        bus.tx_valid = 1'b1;
      end
      if (inject && k == 2) begin
        bus.tx_valid = 1'b0;
        m_buf_full   = 1'b1;
        m_buf        = inj_word;
        check({tag, "_busy_at_consume"}, W'(bus.busy), W'(1));
        check({tag, "_tx_ready_same_cycle"}, W'(bus.tx_ready), '0);
      end
    end

    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        was_reset  = 1'b1;
        m_rx_data  = '0;
        m_buf_full = 1'b0;
        @(negedge clk);
        check({tag, "_busy_after_rst"}, W'(bus.busy), '0);
        check({tag, "_miso_after_rst"}, W'(bus.miso), '0);
      end
      bus.mosi = (i < W) ? word[W-1-i] : extra[i % W];
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b1;
      if (i < W) got = {got[W-2:0], bus.miso};
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    bus.cs = 1'b1;
    repeat (4 * HALF) @(negedge clk);

    if (was_reset) begin
      check({tag, "_rx_valid_count"}, W'(rxv_seen - rxv0), '0);
      check({tag, "_frame_err_count"}, W'(ferr_seen - ferr0), '0);
    end else begin
      n_eff = (nbits < W) ? nbits : W;
      mask  = ~({W{1'b1}} >> n_eff);
      check({tag, "_miso_word"}, got << (W - n_eff), exp_tx & mask);
      check({tag, "_rx_valid_count"}, W'(rxv_seen - rxv0), (nbits >= W) ? W'(1) : '0);
      check({tag, "_frame_err_count"}, W'(ferr_seen - ferr0), (nbits != W) ? W'(1) : '0);
      if (nbits >= W) m_rx_data = word;
    end
    check({tag, "_rx_data"}, bus.rx_data, m_rx_data);
    check({tag, "_tx_ready"}, W'(bus.tx_ready), W'(!m_buf_full));
    check({tag, "_busy_idle"}, W'(bus.busy), '0);
    check({tag, "_miso_idle"}, W'(bus.miso), '0);
  endtask

  initial begin
    int len;
    rst          = 1'b1;
    bus.cs       = 1'b1;
    bus.sck      = 1'b0;
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    m_rx_data    = '0;
    m_buf_full   = 1'b0;
    m_buf        = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_miso", W'(bus.miso), '0);
    check("rst_tx_ready", W'(bus.tx_ready), W'(1));
    check("rst_rx_data", bus.rx_data, '0);
    check("rst_rx_valid", W'(bus.rx_valid), '0);
    check("rst_frame_err", W'(bus.frame_err), '0);
    check("rst_busy", W'(bus.busy), '0);
    repeat (4) @(negedge clk);

    push(32'hA5A5_0F0F);
    send_frame(32'h1234_5678, 32, -1, 1'b0, '0, "basic");
    send_frame(32'hDEAD_BEEF, 32, -1, 1'b0, '0, "underrun");
    send_frame(32'h0BAD_F00D, 32, -1, 1'b0, '0, "underrun2");
    send_frame($urandom, 20, -1, 1'b0, '0, "short");
    send_frame($urandom, 33, -1, 1'b0, '0, "long");

    send_frame(32'h55AA_33CC, 32, -1, 1'b1, 32'hC0FF_EE11, "handshake_n");
    send_frame($urandom, 32, -1, 1'b0, '0, "handshake_n1");

    push($urandom);
    send_frame($urandom, 32, 10, 1'b0, '0, "rst_mid");
    send_frame($urandom, 32, -1, 1'b0, '0, "after_rst");

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) push($urandom);
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : W;
      send_frame($urandom, len, -1, 1'b0, '0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
